// File: rtl/sk6812_pkg.sv
// Shared definitions for the SK6812 chain driver: FSM states, default timings,
// and nanosecond-to-cycle rounding.
package sk6812_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LATCH
    } state_e;

    localparam int DEF_CLK_MHZ  = 12;
    localparam int DEF_T0H_NS   = 300;
    localparam int DEF_T1H_NS   = 600;
    localparam int DEF_BIT_NS   = 1250;
    localparam int DEF_RESET_US = 80;

    // Round to the nearest whole clock cycle.
    function automatic int ns_to_cyc(input int ns, input int clk_mhz);
        return (ns * clk_mhz + 500) / 1000;
    endfunction

endpackage

// File: rtl/sk6812_bit_encoder.sv
// One SK6812 bit slot: high for the bit's high time, low for the rest of the
// BIT_CYC period, with a bit_end strobe on the last cycle of the slot.
module sk6812_bit_encoder #(
    parameter int T0H_CYC = 4,
    parameter int T1H_CYC = 7,
    parameter int BIT_CYC = 15
) (
    input  logic clk,
    input  logic iResetn,
    input  logic i_go,
    input  logic i_bit,
    output logic o_ledstr,
    output logic o_bit_end
);

    localparam int CW = $clog2(BIT_CYC + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_hi;
    logic          r_run;
    logic          r_out;

    assign o_bit_end = r_run && (r_cnt == CW'(BIT_CYC));
    assign o_ledstr  = r_out;

    // r_cnt holds how many cycles of the current slot have already been driven.
    always_ff @(posedge clk) begin
        if (!iResetn) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_run <= 1'b0;
            r_out <= 1'b0;
        end else if (i_go) begin
            r_cnt <= CW'(1);
            r_hi  <= i_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);
            r_run <= 1'b1;
            r_out <= 1'b1;
        end else if (o_bit_end) begin
            r_run <= 1'b0;
            r_out <= 1'b0;
        end else if (r_run) begin
            r_cnt <= r_cnt + CW'(1);
            r_out <= (r_cnt < r_hi);
        end
    end

endmodule

// File: rtl/sk6812_chain_driver.sv
// Streams a buffered chain of SK6812 pixels (GRB or GRBW, MSB first) with a
// latch gap after every frame; optional free-running repeat.
module sk6812_chain_driver
    import sk6812_pkg::*;
#(
    parameter  int NUM_LEDS = 8,
    parameter  int RGBW     = 0,
    parameter  int CLK_MHZ  = DEF_CLK_MHZ,
    parameter  int T0H_NS   = DEF_T0H_NS,
    parameter  int T1H_NS   = DEF_T1H_NS,
    parameter  int BIT_NS   = DEF_BIT_NS,
    parameter  int RESET_US = DEF_RESET_US,
    localparam int BITS     = 24 + 8 * RGBW,
    localparam int AW       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic            clk,
    input  logic            iResetn,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [BITS-1:0] wr_data,
    input  logic            start,
    input  logic            continuous,
    output logic            busy,
    output logic            done,
    output logic            ledstr
);

    localparam int T0H_CYC = ns_to_cyc(T0H_NS, CLK_MHZ);
    localparam int T1H_CYC = ns_to_cyc(T1H_NS, CLK_MHZ);
    localparam int BIT_CYC = ns_to_cyc(BIT_NS, CLK_MHZ);
    localparam int RST_CYC = RESET_US * CLK_MHZ;
    localparam int BW      = $clog2(BITS);
    localparam int LW      = $clog2(RST_CYC + 1);

    if (T1H_CYC >= BIT_CYC || T0H_CYC == 0) begin : g_bad_timing
        $error("sk6812_chain_driver: illegal bit timing");
    end
    if (NUM_LEDS < 1 || NUM_LEDS > 256) begin : g_bad_count
        $error("sk6812_chain_driver: NUM_LEDS out of range");
    end

    // Sized to a power of two so any pixel index is in range; unused entries stay 0.
    logic [BITS-1:0] r_buf [2**AW];
    logic [BITS-1:0] r_shift;
    logic [AW-1:0]   r_pix;
    logic [BW-1:0]   r_bit;
    logic [LW-1:0]   r_lat;
    logic            r_busy;
    logic            r_done;
    state_e          r_state;

    state_e          w_next;
    logic            w_go;
    logic            w_bit;
    logic            w_done;
    logic            w_bit_end;
    logic [AW-1:0]   w_pix_nxt;

    assign w_pix_nxt = r_pix + AW'(1);
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (!iResetn) begin
            for (int i = 0; i < 2**AW; i++) r_buf[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < NUM_LEDS)) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!iResetn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        w_bit  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE:  if (start || continuous) w_next = LOAD;
            LOAD: begin
                w_go   = 1'b1;
                w_bit  = r_buf[0][BITS-1];
                w_next = SEND;
            end
            SEND: if (w_bit_end) begin
                // Next slot starts on the same edge the current one ends.
                if (r_bit != BW'(BITS - 1)) begin
                    w_go  = 1'b1;
                    w_bit = r_shift[BITS-2];
                end else if (r_pix != AW'(NUM_LEDS - 1)) begin
                    w_go  = 1'b1;
                    w_bit = r_buf[w_pix_nxt][BITS-1];
                end else begin
                    w_next = LATCH;
                end
            end
            LATCH: if (r_lat == LW'(RST_CYC - 1)) begin
                w_done = 1'b1;
                w_next = continuous ? LOAD : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!iResetn) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_shift <= '0;
            r_pix   <= '0;
            r_bit   <= '0;
            r_lat   <= '0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= w_done;
            case (r_state)
                LOAD: begin
                    r_shift <= r_buf[0];
                    r_pix   <= '0;
                    r_bit   <= '0;
                    r_lat   <= '0;
                end
                SEND: if (w_bit_end) begin
                    if (r_bit != BW'(BITS - 1)) begin
                        r_shift <= r_shift << 1;
                        r_bit   <= r_bit + BW'(1);
                    end else begin
                        r_shift <= r_buf[w_pix_nxt];
                        r_pix   <= w_pix_nxt;
                        r_bit   <= '0;
                    end
                end
                LATCH:   r_lat <= r_lat + LW'(1);
                default: ;
            endcase
        end
    end

    sk6812_bit_encoder #(
        .T0H_CYC (T0H_CYC),
        .T1H_CYC (T1H_CYC),
        .BIT_CYC (BIT_CYC)
    ) u_enc (
        .clk       (clk),
        .iResetn   (iResetn),
        .i_go      (w_go),
        .i_bit     (w_bit),
        .o_ledstr  (ledstr),
        .o_bit_end (w_bit_end)
    );

endmodule

// File: tb/tb_sk6812_chain_driver.sv
// Bench for the SK6812 chain driver: a 3-pixel GRB chain at 12 MHz and a
// 1-pixel GRBW chain at 24 MHz, checked against a waveform model built from pixel words.
module tb_sk6812_chain_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        iResetn;
    logic        wr_en0, start0, cont0, busy0, done0, led0;
    logic [1:0]  wr_addr0;
    logic [23:0] wr_data0;
    logic        wr_en1, start1, cont1, busy1, done1, led1;
    logic [0:0]  wr_addr1;
    logic [31:0] wr_data1;

    int total = 0;
    int bad   = 0;
    int cur_sel = 0;

    logic [31:0] m0 [0:2];
    logic [31:0] m1;
    logic [31:0] exp_px [0:2];
    int          plan_cyc [0:2];
    int          plan_a   [0:2];
    logic [31:0] plan_d   [0:2];
    logic        cap [0:4095];

    logic led_s, busy_s, done_s;
    assign led_s  = (cur_sel == 1) ? led1  : led0;
    assign busy_s = (cur_sel == 1) ? busy1 : busy0;
    assign done_s = (cur_sel == 1) ? done1 : done0;

    sk6812_chain_driver #(.NUM_LEDS(3), .RGBW(0), .CLK_MHZ(12)) dut0 (
        .clk(clk), .iResetn(iResetn), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .start(start0), .continuous(cont0), .busy(busy0), .done(done0), .ledstr(led0)
    );

    sk6812_chain_driver #(.NUM_LEDS(1), .RGBW(1), .CLK_MHZ(24)) dut1 (
        .clk(clk), .iResetn(iResetn), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .start(start1), .continuous(cont1), .busy(busy1), .done(done1), .ledstr(led1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic write_px(input int sel, input int addr, input logic [31:0] d);
        if (sel == 1) begin
            wr_en1 = 1'b1; wr_addr1 = addr[0:0]; wr_data1 = d;
        end else begin
            wr_en0 = 1'b1; wr_addr0 = addr[1:0]; wr_data0 = d[23:0];
        end
        @(negedge clk);
        wr_en0 = 1'b0;
        wr_en1 = 1'b0;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 1) start1 = v;
        else          start0 = v;
    endtask

    task automatic exp_from_model(input int sel);
        for (int i = 0; i < 3; i++) exp_px[i] = (sel == 1) ? ((i == 0) ? m1 : 32'd0) : m0[i];
    endtask

    // Capture one frame and compare it with the waveform implied by exp_px.
    task automatic run_frame(input int sel, input bit chained, input logic cont_v);
        int nl, pxb, nb, bitc, hi0, hi1, rst, frame, first_done, ones, lead, hi;
        bit busy_ok, run;
        logic v;
        cur_sel = sel;
        pxb  = (sel == 1) ? 32 : 24;
        nl   = (sel == 1) ? 1 : 3;
        nb   = pxb * nl;
        bitc = (sel == 1) ? 30 : 15;
        hi0  = (sel == 1) ? 7 : 4;
        hi1  = (sel == 1) ? 14 : 7;
        rst  = (sel == 1) ? 1920 : 960;
        frame = 1 + nb * bitc + rst;
        if (!chained) begin
            set_start(sel, 1'b1);
            @(posedge clk);
            #1 set_start(sel, 1'b0);
            @(negedge clk);
            check("busy_after_start", busy_s, 1);
            check("led_low_in_load", led_s, 0);
        end
        first_done = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= frame; k++) begin
            @(negedge clk);
            cap[k] = led_s;
            if (done_s && first_done == 0) first_done = k;
            if (k < frame && !busy_s) busy_ok = 1'b0;
            wr_en0 = 1'b0;
            wr_en1 = 1'b0;
            set_start(sel, k == 100);
            for (int p = 0; p < 3; p++) begin
                if (plan_cyc[p] == k) begin
                    wr_en0 = 1'b1; wr_addr0 = plan_a[p][1:0]; wr_data0 = plan_d[p][23:0];
                end
            end
        end
        wr_en0 = 1'b0;
        set_start(sel, 1'b0);
        check("done_cycle", first_done, frame);
        check("busy_held", busy_ok, 1);
        check("busy_at_done", busy_s, cont_v);
        for (int b = 0; b < nb; b++) begin
            v  = exp_px[b / pxb][pxb - 1 - (b % pxb)];
            hi = v ? hi1 : hi0;
            ones = 0; lead = 0; run = 1'b1;
            for (int j = 0; j < bitc; j++) begin
                if (cap[1 + b * bitc + j]) begin
                    ones++;
                    if (run) lead++;
                end else begin
                    run = 1'b0;
                end
            end
            check($sformatf("bit%0d_shape", b), {lead[31:0], ones[31:0]}, {hi[31:0], hi[31:0]});
        end
        ones = 0;
        for (int k = nb * bitc + 1; k <= frame; k++) if (cap[k]) ones++;
        check("latch_low", ones, 0);
        if (!cont_v) begin
            @(negedge clk);
            check("start_not_queued", busy_s, 0);
        end
    endtask

    initial begin
        iResetn = 1'b0;
        start0 = 1'b1; start1 = 1'b1; cont0 = 1'b0; cont1 = 1'b0;
        wr_en0 = 1'b0; wr_en1 = 1'b0; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
        for (int p = 0; p < 3; p++) begin plan_cyc[p] = -1; plan_a[p] = 0; plan_d[p] = 0; m0[p] = 0; end
        m1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led", {led0, led1}, 0);
        check("rst_busy", {busy0, busy1}, 0);
        check("rst_done", {done0, done1}, 0);
        iResetn = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);

        exp_from_model(0);
        run_frame(0, 0, 1'b0);

        m0[0] = 32'hA50000; m0[1] = 32'h000001; m0[2] = $urandom & 32'hFFFFFF;
        for (int i = 0; i < 3; i++) write_px(0, i, m0[i]);
        exp_from_model(0);
        run_frame(0, 0, 1'b0);

        m0[2] = $urandom & 32'hFFFFFF;
        write_px(0, 2, m0[2]);
        cont0 = 1'b1;
        exp_from_model(0);
        run_frame(0, 0, 1'b1);
        cont0 = 1'b0;
        run_frame(0, 1, 1'b0);

        plan_cyc[0] = 50;  plan_a[0] = 1; plan_d[0] = 32'hFFFFFF;
        plan_cyc[1] = 410; plan_a[1] = 0; plan_d[1] = $urandom & 32'hFFFFFF;
        plan_cyc[2] = 600; plan_a[2] = 3; plan_d[2] = $urandom & 32'hFFFFFF;
        exp_px[0] = m0[0]; exp_px[1] = 32'hFFFFFF; exp_px[2] = m0[2];
        run_frame(0, 0, 1'b0);
        for (int p = 0; p < 3; p++) plan_cyc[p] = -1;
        m0[1] = 32'hFFFFFF;
        m0[0] = plan_d[1];
        exp_from_model(0);
        run_frame(0, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                m0[i] = $urandom & 32'hFFFFFF;
                write_px(0, i, m0[i]);
            end
            exp_from_model(0);
            run_frame(0, 0, 1'b0);
        end

        m1 = $urandom;
        write_px(1, 0, m1);
        exp_from_model(1);
        run_frame(1, 0, 1'b0);

        cur_sel = 0;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (197) @(negedge clk);
        check("led_high_before_reset", led0, 1);
        iResetn = 1'b0;
        @(negedge clk);
        check("midframe_rst_led", led0, 0);
        check("midframe_rst_busy", busy0, 0);
        check("midframe_rst_done", done0, 0);
        iResetn = 1'b1;
        for (int i = 0; i < 3; i++) m0[i] = 0;
        m1 = 0;
        @(negedge clk);
        exp_from_model(0);
        run_frame(0, 0, 1'b0);
        exp_from_model(1);
        run_frame(1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
